// File: rtl/mdu_issue_sched.sv
// Oldest-first select for the shared non-pipelined MUL/DIV unit: occupancy countdown,
// early destination wake-up and finish pulse. Define MDU_STAT_EN to add grant/busy counters.
module mdu_issue_sched #(
  parameter int CIQ_DEPTH = 16,
  parameter int AGE_WIDTH = 5,
  parameter int PRF_WIDTH = 6,
  parameter int MUL_LAT   = 3,
  parameter int DIV_LAT   = 20,
  parameter int WAKE_LEAD = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [CIQ_DEPTH-1:0]            req,
  input  logic [CIQ_DEPTH-1:0]            is_div,
  input  logic [CIQ_DEPTH*AGE_WIDTH-1:0]  age_flat,
  input  logic [CIQ_DEPTH*PRF_WIDTH-1:0]  prd_flat,
  input  logic [CIQ_DEPTH-1:0]            prd_v,
  input  logic                            flush,
  output logic                            grant_valid,
  output logic [$clog2(CIQ_DEPTH)-1:0]    grant_addr,
  output logic                            wakeup_valid,
  output logic [PRF_WIDTH-1:0]            wakeup_prd,
  output logic                            fu_busy,
  output logic                            muti_finish
`ifdef MDU_STAT_EN
  ,
  output logic [31:0]                     stat_grant_cnt,
  output logic [31:0]                     stat_busy_cnt
`endif
);

  localparam int IDX_W   = $clog2(CIQ_DEPTH);
  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT);

  typedef enum logic {IDLE, EXEC} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0]     grant_addr_q, grant_addr_d;
  logic [PRF_WIDTH-1:0] prd_q, prd_d;
  logic                 prd_v_q, prd_v_d;

  logic [AGE_WIDTH-1:0] age_w [CIQ_DEPTH];
  logic [PRF_WIDTH-1:0] prd_w [CIQ_DEPTH];
  logic [CIQ_DEPTH-1:0] oldest;
  logic [CIQ_DEPTH-1:0] cand;
  logic [IDX_W-1:0]     win_idx;
  logic                 free;

  function automatic logic older(input logic [AGE_WIDTH-1:0] a, input logic [AGE_WIDTH-1:0] b);
    logic [AGE_WIDTH-1:0] diff;
    diff = a - b;
    return diff[AGE_WIDTH-1];
  endfunction

  for (genvar gi = 0; gi < CIQ_DEPTH; gi++) begin : g_entry
    logic beaten;
    assign age_w[gi] = age_flat[gi*AGE_WIDTH +: AGE_WIDTH];
    assign prd_w[gi] = prd_flat[gi*PRF_WIDTH +: PRF_WIDTH];
    always_comb begin
      beaten = 1'b0;
      for (int j = 0; j < CIQ_DEPTH; j++) begin
        if (j != gi && req[j]) begin
          if (older(age_w[j], age_w[gi]) || (age_w[j] == age_w[gi] && j < gi)) beaten = 1'b1;
        end
      end
    end
    assign oldest[gi] = req[gi] & ~beaten;
  end

  // Wrapped ages can form a cycle with no strict oldest; fall back to the lowest requester.
  always_comb begin
    cand    = (|oldest) ? oldest : req;
    win_idx = '0;
    for (int i = CIQ_DEPTH - 1; i >= 0; i--) begin
      if (cand[i]) win_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    grant_valid_d = 1'b0;
    grant_addr_d  = grant_addr_q;
    prd_d         = prd_q;
    prd_v_d       = prd_v_q;
    free          = (state_q == IDLE) || (cnt_q == '0);
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      prd_d   = '0;
      prd_v_d = 1'b0;
    end else if (free && (|req)) begin
      state_d       = EXEC;
      grant_valid_d = 1'b1;
      grant_addr_d  = win_idx;
      cnt_d         = is_div[win_idx] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
      prd_d         = prd_w[win_idx];
      prd_v_d       = prd_v[win_idx];
    end else if (state_q == EXEC) begin
      if (cnt_q == '0) state_d = IDLE;
      else             cnt_d   = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      grant_valid_q <= 1'b0;
      grant_addr_q  <= '0;
      prd_q         <= '0;
      prd_v_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      grant_valid_q <= grant_valid_d;
      grant_addr_q  <= grant_addr_d;
      prd_q         <= prd_d;
      prd_v_q       <= prd_v_d;
    end
  end

  assign grant_valid  = grant_valid_q;
  assign grant_addr   = grant_addr_q;
  assign fu_busy      = (state_q == EXEC);
  assign muti_finish  = (state_q == EXEC) && (cnt_q == '0);
  assign wakeup_valid = (state_q == EXEC) && (cnt_q == CNT_W'(WAKE_LEAD)) && prd_v_q;
  assign wakeup_prd   = prd_q;

`ifdef MDU_STAT_EN
  logic [31:0] stat_grant_cnt_q, stat_grant_cnt_d;
  logic [31:0] stat_busy_cnt_q, stat_busy_cnt_d;

  always_comb begin
    stat_grant_cnt_d = stat_grant_cnt_q + {31'd0, grant_valid_q};
    stat_busy_cnt_d  = stat_busy_cnt_q + {31'd0, fu_busy};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_grant_cnt_q <= '0;
      stat_busy_cnt_q  <= '0;
    end else begin
      stat_grant_cnt_q <= stat_grant_cnt_d;
      stat_busy_cnt_q  <= stat_busy_cnt_d;
    end
  end

  assign stat_grant_cnt = stat_grant_cnt_q;
  assign stat_busy_cnt  = stat_busy_cnt_q;
`endif

endmodule
